// File: rtl/pipes_sumreduce_pkg.sv
// Shared definitions for the pipes_* reduction stages.
// Holds the float32 field layout, the special encodings used by the
// unsigned-magnitude adder, and the reduction FSM state encoding.
package pipes_sumreduce_pkg;

  localparam int unsigned VARWIDTH = 32;
  localparam int unsigned EXP_BITS = 8;
  localparam int unsigned MAN_BITS = 23;
  localparam int unsigned BIAS     = 127;
  // All-ones exponent (inf/NaN), derived from the bias
  localparam int unsigned EXP_MAX  = 2 * BIAS + 1;

  localparam logic [VARWIDTH-1:0] F32_ZERO = 32'h0000_0000;
  localparam logic [VARWIDTH-1:0] F32_PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pipes_sumreduce_add_f32.sv
// add_f32: combinational float32 adder for non-negative magnitudes.
// Ports:
//   a, b : float32 operands (sign bits ignored)
//   sum  : float32 result, sign always 0
// Zero-exponent operands are flushed to zero, inf/NaN operands or an
// exponent overflow give +inf, and the result is truncated toward zero.
module add_f32
  import pipes_sumreduce_pkg::*;
(
  input  logic [VARWIDTH-1:0] a,
  input  logic [VARWIDTH-1:0] b,
  output logic [VARWIDTH-1:0] sum
);

  localparam int unsigned MW = MAN_BITS + 1;  // mantissa including hidden bit

  logic [EXP_BITS-1:0] ea, eb, big_e, small_e, diff;
  logic [MW-1:0]       ma, mb, big_m, small_m, small_sh;
  logic [MW:0]         msum;
  logic [EXP_BITS:0]   e_res;
  logic [MAN_BITS-1:0] m_res;

  logic unused_signs;
  assign unused_signs = a[VARWIDTH-1] ^ b[VARWIDTH-1];

  always_comb begin
    ea = a[VARWIDTH-2 -: EXP_BITS];
    eb = b[VARWIDTH-2 -: EXP_BITS];
    ma = (ea == '0) ? '0 : {1'b1, a[MAN_BITS-1:0]};
    mb = (eb == '0) ? '0 : {1'b1, b[MAN_BITS-1:0]};

    if (ea >= eb) begin
      big_e = ea; big_m = ma; small_e = eb; small_m = mb;
    end else begin
      big_e = eb; big_m = mb; small_e = ea; small_m = ma;
    end

    diff     = big_e - small_e;
    small_sh = (diff >= EXP_BITS'(MW + 1)) ? '0 : (small_m >> diff);
    msum     = {1'b0, big_m} + {1'b0, small_sh};

    // Both operands non-negative, so the only renormalisation is a carry-out
    if (msum[MW]) begin
      e_res = {1'b0, big_e} + (EXP_BITS + 1)'(1);
      m_res = msum[MW-1:1];
    end else begin
      e_res = {1'b0, big_e};
      m_res = msum[MAN_BITS-1:0];
    end

    if ((ea == EXP_BITS'(EXP_MAX)) || (eb == EXP_BITS'(EXP_MAX)) ||
        (e_res >= (EXP_BITS + 1)'(EXP_MAX))) begin
      sum = F32_PINF;
    end else begin
      sum = {1'b0, e_res[EXP_BITS-1:0], m_res};
    end
  end

endmodule

// File: rtl/pipes_sumreduce.sv
// pipes_sumreduce: serial float32 sum of a WIDTH-lane vector.
// Captures one vector per transaction, adds one lane per enabled cycle,
// then holds the sum behind a valid/ready handshake.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   EN                : stage enable; all state holds while low
//   in_valid/in_ready : input vector handshake
//   vals              : packed lanes, lane k at vals[k*32 +: 32]
//   out_valid/out_ready : result handshake
//   sum               : accumulated float32 sum
//   ovf               : (only with PIPES_SUMREDUCE_OVF_EN) saturation seen
// Optional feature macro: PIPES_SUMREDUCE_OVF_EN
module pipes_sumreduce
  import pipes_sumreduce_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VARWIDTH*WIDTH-1:0] vals,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VARWIDTH-1:0]       sum
`ifdef PIPES_SUMREDUCE_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [VARWIDTH-1:0] acc_q, acc_d;
  logic [VARWIDTH-1:0] sum_q, sum_d;
  logic [VARWIDTH-1:0] lane_q [WIDTH];
  logic [VARWIDTH-1:0] add_res;
  logic                load;

  add_f32 u_add (
    .a   (acc_q),
    .b   (lane_q[idx_q]),
    .sum (add_res)
  );

`ifdef PIPES_SUMREDUCE_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    load    = 1'b0;
`ifdef PIPES_SUMREDUCE_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            acc_d   = F32_ZERO;
            idx_d   = '0;
            state_d = ACC;
`ifdef PIPES_SUMREDUCE_OVF_EN
            ovf_d   = 1'b0;
`endif
          end
        end
        ACC: begin
          acc_d = add_res;
          idx_d = idx_q + IDXW'(1);
`ifdef PIPES_SUMREDUCE_OVF_EN
          // +inf only arises from an inf/NaN lane or exponent overflow
          ovf_d = ovf_q | (add_res == F32_PINF);
`endif
          if (idx_q == IDXW'(WIDTH - 1)) begin
            idx_d   = '0;
            sum_d   = add_res;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= F32_ZERO;
      sum_q   <= F32_ZERO;
      for (int k = 0; k < int'(WIDTH); k++) lane_q[k] <= F32_ZERO;
`ifdef PIPES_SUMREDUCE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      if (load) begin
        for (int k = 0; k < int'(WIDTH); k++) lane_q[k] <= vals[k*VARWIDTH +: VARWIDTH];
      end
`ifdef PIPES_SUMREDUCE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !RST;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
`ifdef PIPES_SUMREDUCE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipes_sumreduce.sv
// Self-checking bench for pipes_sumreduce (WIDTH=16).
// Reference: float32 values are turned into reals, summed exactly, then
// truncated back to 24 significant bits; inf/NaN inputs and exponent >= 255
// give +inf. A scoreboard of accepted vectors is checked every cycle.
module tb_pipes_sumreduce;

  localparam int W = 16;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  logic          CLK = 1'b0;
  logic          RST, EN, in_valid, in_ready, out_valid, out_ready;
  logic [32*W-1:0] vals;
  logic [31:0]   sum;
`ifdef PIPES_SUMREDUCE_OVF_EN
  logic          ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipes_sumreduce #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vals      (vals),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef PIPES_SUMREDUCE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    int e = int'(f[30:23]);
    if (e == 0) return 0.0;
    return real'(int'({1'b1, f[22:0]})) * pow2(e - 150);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real y = x;
    int  e = 127;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    while (y >= 2.0) begin y = y / 2.0; e++; end
    while (y < 1.0) begin y = y * 2.0; e--; end
    if (e >= 255) return PINF;
    m = 23'($rtoi((y - 1.0) * 8388608.0));
    return {1'b0, 8'(e), m};
  endfunction

  function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return PINF;
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] model_vec(input logic [32*W-1:0] v);
    logic [31:0] acc = 32'h0;
    for (int k = 0; k < W; k++) acc = add_ref(acc, v[k*32 +: 32]);
    return acc;
  endfunction

  function automatic logic [31:0] rand_lane();
    int unsigned r = $urandom_range(0, 99);
    logic [31:0] x;
    x = $urandom;
    if (r < 5)       x[30:23] = 8'h00;
    else if (r < 7)  x[30:23] = 8'hFF;
    else if (r < 10) x[30:23] = 8'(250 + $urandom_range(0, 4));
    else             x[30:23] = 8'(110 + $urandom_range(0, 25));
    return x;
  endfunction

  function automatic logic [32*W-1:0] rand_vec();
    logic [32*W-1:0] r;
    for (int k = 0; k < W; k++) r[k*32 +: 32] = rand_lane();
    return r;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp  = 32'h0;
  logic [31:0] sum_last = 32'h0;
  bit          have_cur  = 1'b0;
  bit          delivered = 1'b0;
  int          pending   = 0;

  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      have_cur  = 1'b0;
      delivered = 1'b0;
      sum_last  = 32'h0;
      pending   = 0;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_sum", sum, 32'h0);
    end else begin
      pending = exp_q.size() + int'(have_cur);
      if (delivered) check("valid_drop", 32'(out_valid), 32'h0);
      delivered = 1'b0;
      check("in_ready", 32'(in_ready), 32'(pending == 0));
      if (out_valid && !have_cur) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'h0);
        else begin
          cur_exp  = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("valid_held", 32'(out_valid), 32'h1);
        check("sum", sum, cur_exp);
`ifdef PIPES_SUMREDUCE_OVF_EN
        check("ovf", 32'(ovf), 32'(cur_exp == PINF));
`endif
        sum_last = cur_exp;
        if (out_ready && EN) begin
          delivered = 1'b1;
          have_cur  = 1'b0;
        end
      end else if (!out_valid) begin
        check("sum_hold", sum, sum_last);
      end
      if (in_valid && in_ready && EN) exp_q.push_back(model_vec(vals));
    end
  end

  // ---------------- driver ----------------
  // lat counts rising edges from the accepting edge (inclusive) until
  // out_valid is observed; acc_wait is the number of refused cycles.
  task automatic run_txn(input logic [32*W-1:0] v, input int stall_at, input int stall_len,
                         input int rst_at, output int lat, output int acc_wait);
    int cnt;
    bit ok = 1'b0;
    lat      = -1;
    acc_wait = -1;
    vals     = v;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (in_ready && EN && !RST) begin ok = 1'b1; acc_wait = i; break; end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      if (cnt == rst_at) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        return;
      end
      if (cnt == stall_at) EN = 1'b0;
      if (cnt == stall_at + stall_len) EN = 1'b1;
      @(negedge CLK);
      if (out_valid) begin lat = cnt; return; end
      @(posedge CLK); #1;
      cnt++;
    end
    fail("result_timeout");
  endtask

  initial begin
    #1_000_000;
    fail("watchdog");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  logic [32*W-1:0] v_ones, v_mix, v_big;
  int lat, aw;

  initial begin
    RST = 1'b1; EN = 1'b1; in_valid = 1'b0; out_ready = 1'b1; vals = '0;

    // pin the model with hand-computed values
    check("m_1p1", add_ref(32'h3F800000, 32'h3F800000), 32'h40000000);
    check("m_trunc", add_ref(32'h3F800001, 32'h3F800000), 32'h40000000);
    check("m_sign", add_ref(32'hBF800000, 32'h3F800000), 32'h40000000);
    check("m_flush", add_ref(32'h00400000, 32'h3F800000), 32'h3F800000);
    check("m_shift24", add_ref(32'h3F800000, 32'h33800000), 32'h3F800000);
    check("m_carry", add_ref(32'h3FFFFFFF, 32'h3FFFFFFF), 32'h407FFFFF);
    check("m_sat", add_ref(32'h7F000000, 32'h7F000000), PINF);
    check("m_nan", add_ref(32'h7FC00000, 32'h00000000), PINF);

    v_ones = '0; v_mix = '0; v_big = '0;
    for (int k = 0; k < W; k++) v_ones[k*32 +: 32] = 32'h3F800000;
    v_mix[3*32 +: 32] = 32'h40000000;
    v_mix[9*32 +: 32] = 32'h3F000000;
    v_big[0 +: 32]  = 32'h7F000000;
    v_big[32 +: 32] = 32'h7F000000;
    check("m_ones", model_vec(v_ones), 32'h41800000);

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("in_ready_after_rst", 32'(in_ready), 32'h1);
    @(posedge CLK); #1;

    // all ones: latency and sum
    run_txn(v_ones, -1, 0, -1, lat, aw);
    check("lat_ones", 32'(lat), 32'(W + 1));
    check("sum_ones", sum, 32'h41800000);
    @(posedge CLK); #1;

    run_txn(v_mix, -1, 0, -1, lat, aw);
    check("sum_mix", sum, 32'h40200000);
    @(posedge CLK); #1;

    run_txn(v_big, -1, 0, -1, lat, aw);
    check("sum_sat", sum, PINF);
`ifdef PIPES_SUMREDUCE_OVF_EN
    check("ovf_sat", 32'(ovf), 32'h1);
`endif
    @(posedge CLK); #1;

    // backpressure with a new vector waiting
    out_ready = 1'b0;
    run_txn(v_ones, -1, 0, -1, lat, aw);
    @(posedge CLK); #1;
    vals = v_mix;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_sum", sum, 32'h41800000);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    run_txn(v_mix, -1, 0, -1, lat, aw);
    check("bp_accept_wait", 32'(aw), 32'h1);
    check("bp_sum2", sum, 32'h40200000);
    @(posedge CLK); #1;

    // EN stall of 5 cycles mid-accumulation
    run_txn(v_ones, 5, 5, -1, lat, aw);
    check("lat_stall", 32'(lat), 32'(W + 1 + 5));
    check("sum_stall", sum, 32'h41800000);
    @(posedge CLK); #1;

    // reset while idx == 7
    run_txn(v_ones, -1, 0, 8, lat, aw);
    @(negedge CLK);
    check("rst_mid_valid", 32'(out_valid), 32'h0);
    check("rst_mid_sum", sum, 32'h0);
    check("rst_mid_ready", 32'(in_ready), 32'h1);
    repeat (25) @(posedge CLK);
    #1;
    run_txn(v_mix, -1, 0, -1, lat, aw);
    check("sum_after_rst", sum, 32'h40200000);

    // randomized traffic, checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      EN        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) vals = rand_vec();
      RST       = ($urandom_range(0, 599) == 0);
    end
    @(posedge CLK); #1;
    EN = 1'b1; out_ready = 1'b1; in_valid = 1'b0; RST = 1'b0;
    repeat (60) @(posedge CLK);
    @(negedge CLK);
    check("drain_pending", 32'(pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipes_sumreduce.md
Name: pipes_sumreduce

Overview:
- Stage directly downstream of pipes_diffsquare.
- Consumes one WIDTH-lane vector of float32 squared differences per transaction.
- Serially accumulates the lanes, one per cycle, into a single float32 sum (squared Euclidean distance).
- Presents the sum through a valid/ready handshake to the distance/compare logic.

Parameters:
- WIDTH, 16, number of 32-bit lanes in the input vector; legal range 1..256.
- VARWIDTH (localparam), 32, lane width; fixed to float32.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- EN  input  1  stage enable; when low, all state holds (stall).
- in_valid  input  1  input vector valid.
- in_ready  output  1  stage can accept a vector.
- vals  input  VARWIDTH*WIDTH  packed lanes; lane k = vals[(k+1)*32-1 : k*32].
- out_valid  output  1  sum valid.
- out_ready  input  1  downstream accepts sum.
- sum  output  32  float32 accumulated sum.

Behaviour:
- Reset: state=IDLE, in_ready=0 during reset then 1, out_valid=0, sum=0x00000000, lane buffer cleared, index=0.
- FSM states IDLE, ACC, DONE. Every transition is gated by EN; with EN=0 all registers hold.
- IDLE:
  - in_ready=1.
  - On in_valid & EN at an edge: capture vals into lane buffer, acc=0, idx=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each edge: acc <= add_f32(acc, lane[idx]); idx++.
  - When idx==WIDTH-1 is consumed, go to DONE.
- DONE:
  - out_valid=1, sum=acc.
  - On out_ready & EN: go to IDLE; out_valid drops next cycle.
  - sum holds its value until the next transaction completes.
- Latency: with EN=1 and out_ready=1, out_valid rises WIDTH+1 edges after the accepting edge.
- Throughput: one vector per WIDTH+2 cycles. No overlap: in_ready is 0 in ACC and DONE.
- Backpressure: out_ready=0 in DONE holds sum and out_valid indefinitely. in_valid is ignored.
- Arithmetic (add_f32, unsigned magnitudes):
  - Input sign bits are ignored; the result sign is always 0.
  - Exponent 0 is flushed to zero.
  - Exponent 255 (inf/NaN) on either operand gives 0x7F800000.
  - Align by right-shifting the smaller mantissa (hidden bit restored); shifts of 25 or more yield 0.
  - 25-bit add; on carry, shift right 1 and increment the exponent.
  - Rounding is truncation (toward zero).
  - Result exponent of 255 or more saturates to 0x7F800000, and the sum stays saturated.
- RST asserted mid-ACC or mid-DONE: immediate return to the reset state; the partial sum is discarded and no out_valid is produced.
- WIDTH=1: ACC lasts one edge; sum equals the single lane (flushed/truncated per the rules above).

Optional Feature:
- Macro: PIPES_SUMREDUCE_OVF_EN.
- With the macro: extra output port ovf (1 bit).
  - Reset 0; cleared on accept.
  - Set and sticky for the transaction if any add saturates or any lane has exponent 255.
  - Valid alongside out_valid.
- Without the macro: port absent; saturation behaviour is unchanged.

Decomposition:
- Shared package/include:
  - VARWIDTH=32.
  - Float field constants: EXP_BITS=8, MAN_BITS=23, BIAS=127.
  - F32_ZERO=32'h00000000, F32_PINF=32'h7F800000.
  - FSM state encodings IDLE/ACC/DONE.
- One combinational sub-module: add_f32 (a, b, sum), implementing the arithmetic rules above. It is reusable by other reduction stages.
- The FSM, lane buffer and index counter stay in pipes_sumreduce.

Test Plan:
- All 16 lanes 0x3F800000 (1.0), EN=1, out_ready=1 -> out_valid 17 edges after accept; sum=0x41800000 (16.0).
- Lane 3=0x40000000 (2.0), lane 9=0x3F000000 (0.5), rest 0 -> sum=0x40200000 (2.5).
- Lanes 0,1=0x7F000000, rest 0 -> sum=0x7F800000; ovf=1 with the macro defined.
- out_ready=0 for 10 cycles in DONE, with in_valid=1 and a new vector applied -> sum, out_valid held; in_ready=0; second vector accepted only after out_ready pulse.
- EN low for 5 cycles mid-ACC -> idx/acc frozen; the final sum is identical to the unstalled run; latency extended by exactly 5.
- RST pulse at ACC idx=7 -> out_valid=0, sum=0, in_ready=1 after release; the next vector produces the correct sum.
